// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-ported memory bus
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_done,
    output logic        o_if_stall,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [1:0]  i_dm_size,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_done,
    output logic        o_dm_stall,
    output logic        o_mem_valid,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_size,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic [1:0]  o_grant_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_grant_fetch;
    logic        w_grant_data;

    logic        r_owner;
    logic [3:0]  r_starve_cnt;
    logic        r_mem_valid;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_size;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_done;
    logic        r_dm_done;
    logic [1:0]  r_grant_dbg;

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and arbitration: data wins unless fetch has lost LIMIT times in a row
    always_comb begin
        w_state_next  = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_if_req || i_dm_req) begin
                    w_state_next = S_BUSY;
                    if (i_if_req && (!i_dm_req || r_starve_cnt == LIMIT)) begin
                        w_grant_fetch = 1'b1;
                    end else begin
                        w_grant_data = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (i_mem_ready) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bus field latch, starvation counter, read-data capture and done pulses
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_owner      <= OWNER_FETCH;
            r_starve_cnt <= 4'd0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_size   <= 2'b10;
            r_if_rdata   <= 32'd0;
            r_dm_rdata   <= 32'd0;
            r_if_done    <= 1'b0;
            r_dm_done    <= 1'b0;
            r_grant_dbg  <= 2'b00;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            if (w_grant_fetch) begin
                r_owner      <= OWNER_FETCH;
                r_mem_valid  <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= i_if_addr;
                r_mem_wdata  <= 32'd0;
                r_mem_size   <= 2'b10;
                r_grant_dbg  <= 2'b01;
                r_starve_cnt <= 4'd0;
            end
            if (w_grant_data) begin
                r_owner     <= OWNER_DATA;
                r_mem_valid <= 1'b1;
                r_mem_we    <= i_dm_we;
                r_mem_addr  <= i_dm_addr;
                r_mem_wdata <= i_dm_wdata;
                r_mem_size  <= i_dm_size;
                r_grant_dbg <= 2'b10;
                if (i_if_req && r_starve_cnt < LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
            if (r_state == S_BUSY && i_mem_ready) begin
                r_mem_valid <= 1'b0;
                if (r_owner == OWNER_DATA) begin
                    r_dm_rdata <= i_mem_rdata;
                    r_dm_done  <= 1'b1;
                end else begin
                    r_if_rdata <= i_mem_rdata;
                    r_if_done  <= 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_grant_dbg <= 2'b00;
            end
        end
    end

    assign o_if_stall  = i_if_req & ~r_if_done;
    assign o_dm_stall  = i_dm_req & ~r_dm_done;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_done   = r_if_done;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_done   = r_dm_done;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_size  = r_mem_size;
    assign o_grant_dbg = r_grant_dbg;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory bus between the pipeline's instruction-fetch side and its load/store (MEM-stage) side. It latches the winning request, drives a valid/ready transaction on the shared bus, and returns read data with a one-cycle done pulse to the owner. Fixed priority favours data accesses, with a bounded-starvation guard for fetch. It sits between the IFU/MEM-stage request logic and the unified memory model. Hazard logic converts the stall outputs into pipeline stalls.

## Interface
- STARVE_LIMIT, 4: consecutive fetch losses tolerated before fetch is forced to win. Legal range 1..15.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched word; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_done.
- dm_req  in  1  data request; held with dm_* until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_size  in  2  00 byte, 01 half, 10 word; forwarded unchanged.
- dm_rdata  out  32  load data; valid while dm_done=1.
- dm_done  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  dm_req & ~dm_done.
- mem_valid  out  1  shared-bus request valid.
- mem_we, mem_addr, mem_wdata, mem_size  out  1/32/32/2  latched request fields.
- mem_ready  in  1  memory accepts/completes the transaction in this cycle.
- mem_rdata  in  32  read data, valid with mem_ready.
- grant_dbg  out  2  00 none, 01 fetch, 10 data.

## Operation
- FSM states: IDLE, BUSY, RESP. An owner register (FETCH/DATA) is loaded on grant.
- IDLE:
  - If neither request is present, stay in IDLE.
  - Otherwise grant, latch the bus fields (fetch grant: mem_we=0, mem_size=10, mem_wdata=0), and go to BUSY.
- Arbitration, with both requests present:
  - If starve_cnt == STARVE_LIMIT, fetch wins; otherwise data wins.
  - When only one request is present, it wins.
- starve_cnt (4-bit):
  - +1 when data wins while if_req=1.
  - Cleared to 0 on every fetch grant.
  - Saturates at STARVE_LIMIT.
- BUSY:
  - mem_valid=1 with the latched fields held stable.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register (stores capture too; value is don't-care for the requester) and go to RESP.
  - On mem_ready=0: stay in BUSY. No timeout.
- RESP:
  - Owner's done=1 for exactly one cycle.
  - Unconditionally go to IDLE. Requests are not sampled in RESP.
- Requester rule: a requester that keeps req high through the edge ending its done cycle issues a new, independent request, arbitrated in the following IDLE cycle.
- grant_dbg reflects the owner in BUSY and RESP, and is 00 in IDLE.
- Reset (async, at any time, including mid-BUSY):
  - State→IDLE, mem_valid=0, done pulses 0, rdata registers 0.
  - starve_cnt=0, latched fields 0 (mem_size=10), grant_dbg=00.
  - The in-flight transaction is abandoned; the memory model must tolerate mem_valid dropping.

## Timing
- A request seen in IDLE at edge N gives mem_valid=1 in cycle N+1.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle) gives done in cycle N+2, so the minimum request-to-done latency is 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Back-to-back throughput: one transaction per 3 cycles (IDLE, BUSY, RESP) at zero wait.
- The non-owner's stall stays high for the whole transaction.
- A request raised during BUSY/RESP is first arbitrated in the next IDLE cycle.
- if_stall and dm_stall are combinational from req and the registered done.
- All other outputs are registered.

## Test plan
- Reset state: hold reset_n=0 → all outputs 0, mem_size=10, grant_dbg=00. Release it with no requests → stays in IDLE, mem_valid=0.
- Single zero-wait fetch: if_req with if_addr=0x0000_0010; memory returns 0x0000_0093 with mem_ready=1 in the first BUSY cycle.
  - mem_valid/mem_addr=0x10 in cycle +1.
  - if_done=1 and if_rdata=0x93 in cycle +2.
- Store with wait states: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_size=00; memory inserts 3 wait cycles.
  - mem_* held stable for 4 BUSY cycles.
  - dm_done in cycle +5.
  - if_stall high throughout while if_req=1.
- Collision and starvation guard (STARVE_LIMIT=4): hold if_req and dm_req continuously, with dm_req re-raised after each dm_done.
  - Data is granted 4 times, then fetch is granted on the 5th arbitration.
  - starve_cnt returns to 0 and the pattern repeats.
- Back-to-back: dm_req held through the done cycle with a new address → second transaction has mem_valid exactly 3 cycles after the first.
- Reset mid-transaction: assert reset_n=0 in the second BUSY cycle → mem_valid drops immediately and no done pulse occurs. After release, a pending if_req is granted normally.
